nios_fprint_scratchpad_arbiter: RTL
===================================

// Module: nios_fprint_scratchpad_arbiter
// PURPOSE
//  Shares one single-port scratchpad RAM (1-cycle read latency, registered addr, unregistered q)
//  between two Avalon-MM requesters: port A (Nios core data master) and port B (fingerprint/DMA unit).
//  One access is granted per cycle. A grant may hold for up to MAX_HOLD back-to-back accesses under
//  contention, then passes to the other port. Sits between the interconnect and the RAM wrapper.
// PARAMETERS
//  ADDR_W    12  word address width (4096 x 32-bit words)
//  DATA_W    32  data width
//  BE_W       4  byteenable width (DATA_W/8)
//  MAX_HOLD   4  max consecutive grants to one port while the other is requesting (>=1)
// PORTS
//  clk              in   1       system clock
//  reset            in   1       synchronous, active-high reset
//  reset_req        in   1       reset request: freeze RAM clock enable, block new grants
//  a_address        in   ADDR_W  port A word address
//  a_byteenable     in   BE_W    port A byte lanes (writes only)
//  a_read           in   1       port A read request
//  a_write          in   1       port A write request
//  a_writedata      in   DATA_W  port A write data
//  a_waitrequest    out  1       port A stall; low = request accepted this cycle
//  a_readdata       out  DATA_W  port A read data
//  a_readdatavalid  out  1       port A read data valid
//  b_*              -    -       identical set for port B
//  ram_address      out  ADDR_W  to RAM address
//  ram_byteenable   out  BE_W    to RAM byteenable
//  ram_chipselect   out  1       to RAM chipselect
//  ram_write        out  1       to RAM write
//  ram_writedata    out  DATA_W  to RAM writedata
//  ram_clken        out  1       to RAM clken
//  ram_readdata     in   DATA_W  from RAM q (valid 1 cycle after read address)
// BEHAVIOUR
//  - State regs: last_grant (A/B), hold_cnt [0..MAX_HOLD], rd_pend_a, rd_pend_b.
//  - Reset (sync): last_grant=B, hold_cnt=MAX_HOLD, rd_pend_*=0. While reset=1: both waitrequest=1,
//    ram_chipselect=0, ram_write=0, readdatavalid=0. Reset mid-read drops the pending read (no valid).
//  - req_x = x_read | x_write. A port asserting read and write together is treated as write.
//  - Grant (combinational, only when reset=0 and reset_req=0):
//    only one req -> that port; both -> last_grant port if hold_cnt<MAX_HOLD, else the other; none -> idle.
//  - Granted port: waitrequest=0 same cycle; ram_* driven from its address/byteenable/writedata;
//    ram_chipselect=1; ram_write=x_write. Ungranted requesting port: waitrequest=1, must hold inputs.
//  - Idle: waitrequest=1 on both ports (no request, or reset_req=1).
//  - On grant edge: if port == last_grant, hold_cnt <= sat(hold_cnt+1, MAX_HOLD); else hold_cnt <= 1,
//    last_grant <= port. Idle cycles leave last_grant/hold_cnt unchanged.
//  - Read latency: granted read at cycle N -> x_readdatavalid=1 at N+1 with x_readdata=ram_readdata.
//    rd_pend_x <= (grant to x & x_read & ~x_write). Reads are fully pipelined: 1 access/cycle.
//  - x_readdata is a direct route of ram_readdata (both ports); qualify only by readdatavalid.
//  - Writes: complete in the grant cycle, no response. Read at N+1 to same address returns new data.
//  - ram_clken = ~reset_req. reset_req asserted while a read is pending: readdatavalid still issued at
//    N+1 (RAM output is unregistered, q held); no new grants until reset_req=0.
//  - Fairness: under continuous contention, grants follow MAX_HOLD to A/B alternately (A first after reset).
// TESTING
//  1 Reset: after reset, a_read=b_read=0 -> both waitrequest=1, readdatavalid=0, ram_chipselect=0.
//  2 Single port: A writes 0xDEADBEEF @0x010 be=4'hF, then reads 0x010 -> waitrequest=0 each cycle,
//    a_readdatavalid=1 one cycle later with 0xDEADBEEF; b_readdatavalid stays 0.
//  3 Contention, MAX_HOLD=4: A and B read continuously from cycle 0 -> grants AAAA BBBB AAAA...,
//    each readdatavalid on the owning port exactly 1 cycle after its grant, 1 datum per cycle total.
//  4 Byte lanes: A writes 0x11223344 @0x020, B writes 0xAABBCCDD be=4'b0101 @0x020, A reads
//    -> 0x11BB33DD.
//  5 reset_req: assert during B read stream -> B's in-flight read returns valid at N+1, then both
//    waitrequest=1 and ram_clken=0 until reset_req=0; no readdatavalid in between.
//  6 Reset mid-operation: reset=1 in the cycle after an A read grant -> a_readdatavalid stays 0,
//    next tie after reset goes to A.

Source files
------------

// File: rtl/nios_fprint_scratchpad_arbiter_if.sv
// Avalon-MM requester port bundle shared by both sides of the scratchpad arbiter.
interface nios_fprint_scratchpad_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BE_W   = 4
);
  logic [ADDR_W-1:0] address;
  logic [BE_W-1:0]   byteenable;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, byteenable, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, byteenable, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/nios_fprint_scratchpad_arbiter.sv
// Two-requester arbiter in front of a single-port scratchpad RAM (1-cycle read latency).
// Bounded-hold round robin: a port keeps the grant for at most MAX_HOLD accesses under contention.
module nios_fprint_scratchpad_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned BE_W     = 4,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reset_req,
  nios_fprint_scratchpad_arbiter_if.slave a_port,
  nios_fprint_scratchpad_arbiter_if.slave b_port,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [BE_W-1:0]     ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int unsigned CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  owner_e           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             rd_pend_a_q, rd_pend_a_d;
  logic             rd_pend_b_q, rd_pend_b_d;

  logic             req_a, req_b;
  logic             grant_a, grant_b;
  owner_e           owner_c;

  // Arbitration state; reset leaves B as last owner with an exhausted hold so the first tie goes to A
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= OWNER_B;
      hold_cnt_q   <= HOLD_MAX;
      rd_pend_a_q  <= 1'b0;
      rd_pend_b_q  <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      rd_pend_a_q  <= rd_pend_a_d;
      rd_pend_b_q  <= rd_pend_b_d;
    end
  end

  // Grant decision, next state and the RAM/port routing
  always_comb begin
    last_grant_d         = last_grant_q;
    hold_cnt_d           = hold_cnt_q;
    rd_pend_a_d          = 1'b0;
    rd_pend_b_d          = 1'b0;
    grant_a              = 1'b0;
    grant_b              = 1'b0;
    owner_c              = last_grant_q;
    ram_address          = a_port.address;
    ram_byteenable       = a_port.byteenable;
    ram_writedata        = a_port.writedata;
    ram_write            = 1'b0;
    ram_chipselect       = 1'b0;
    ram_clken            = ~reset_req;

    req_a = a_port.read | a_port.write;
    req_b = b_port.read | b_port.write;

    if (!reset && !reset_req) begin
      if (req_a && req_b) begin
        if (hold_cnt_q < HOLD_MAX) begin
          grant_a = (last_grant_q == OWNER_A);
        end else begin
          grant_a = (last_grant_q == OWNER_B);
        end
        grant_b = ~grant_a;
      end else begin
        grant_a = req_a;
        grant_b = req_b;
      end
    end

    if (grant_a || grant_b) begin
      owner_c        = grant_a ? OWNER_A : OWNER_B;
      ram_chipselect = 1'b1;
      if (owner_c == last_grant_q) begin
        hold_cnt_d = (hold_cnt_q == HOLD_MAX) ? HOLD_MAX : hold_cnt_q + CNT_W'(1);
      end else begin
        hold_cnt_d   = CNT_W'(1);
        last_grant_d = owner_c;
      end
    end

    if (grant_b) begin
      ram_address    = b_port.address;
      ram_byteenable = b_port.byteenable;
      ram_writedata  = b_port.writedata;
      ram_write      = b_port.write;
    end else if (grant_a) begin
      ram_write      = a_port.write;
    end

    // Read+write together counts as a write, so it never schedules read data
    rd_pend_a_d = grant_a & a_port.read & ~a_port.write;
    rd_pend_b_d = grant_b & b_port.read & ~b_port.write;

    a_port.waitrequest   = ~grant_a;
    b_port.waitrequest   = ~grant_b;
    a_port.readdatavalid = rd_pend_a_q & ~reset;
    b_port.readdatavalid = rd_pend_b_q & ~reset;
    a_port.readdata      = ram_readdata;
    b_port.readdata      = ram_readdata;
  end

endmodule
